// File: rtl/fp_pkg.sv
// Shared widths and output-stage state for the floating-point multiplier arbiter.
package fp_pkg;

  localparam int EXP_WIDTH_DEF  = 8;
  localparam int MANT_WIDTH_DEF = 23;
  localparam int NUM_REQ_DEF    = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/fp_mul_arbiter_fpmul.sv
// Combinational IEEE-754 style multiplier: round-to-nearest-even, subnormal inputs,
// results below the normal range flush to signed zero and raise underflow.
module floating_point_multiplier #(
  parameter int ExponentWidth = 8,
  parameter int MantissaWidth = 23
) (
  input  logic [ExponentWidth+MantissaWidth:0] a_i,
  input  logic [ExponentWidth+MantissaWidth:0] b_i,
  output logic [ExponentWidth+MantissaWidth:0] p_o,
  output logic                                 underflow_o,
  output logic                                 overflow_o,
  output logic                                 invalid_o
);
  localparam int EW   = ExponentWidth;
  localparam int MW   = MantissaWidth;
  localparam int W    = EW + MW + 1;
  localparam int PW   = 2 * (MW + 1);
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic [EW-1:0] ea_s, eb_s;
  logic [MW-1:0] ma_s, mb_s;
  logic          sign_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [PW-1:0] prod_s, norm_s;
  logic [MW:0]   mant_r_s;
  logic          round_s;
  int            lead_s, exp_s;

  assign sign_s   = a_i[W-1] ^ b_i[W-1];
  assign ea_s     = a_i[W-2:MW];
  assign eb_s     = b_i[W-2:MW];
  assign ma_s     = a_i[MW-1:0];
  assign mb_s     = b_i[MW-1:0];
  assign a_nan_s  = (ea_s == {EW{1'b1}}) && (ma_s != '0);
  assign b_nan_s  = (eb_s == {EW{1'b1}}) && (mb_s != '0);
  assign a_inf_s  = (ea_s == {EW{1'b1}}) && (ma_s == '0);
  assign b_inf_s  = (eb_s == {EW{1'b1}}) && (mb_s == '0);
  assign a_zero_s = (ea_s == '0) && (ma_s == '0);
  assign b_zero_s = (eb_s == '0) && (mb_s == '0);
  assign prod_s   = PW'({ea_s != '0, ma_s}) * PW'({eb_s != '0, mb_s});

  // Normalise on the leading one so subnormal operands land correctly, then round.
  always_comb begin
    lead_s = 0;
    for (int i = 0; i < PW; i++) begin
      lead_s = prod_s[i] ? i : lead_s;
    end
    norm_s   = prod_s << (PW - 1 - lead_s);
    round_s  = norm_s[PW-2-MW] & ((|norm_s[PW-3-MW:0]) | norm_s[PW-1-MW]);
    mant_r_s = {1'b0, norm_s[PW-2 -: MW]} + {{MW{1'b0}}, round_s};
    exp_s    = ((ea_s == '0) ? 1 : int'(ea_s)) + ((eb_s == '0) ? 1 : int'(eb_s))
               - BIAS + lead_s - (PW - 2) + int'(mant_r_s[MW]);
  end

  always_comb begin
    p_o         = '0;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    invalid_o   = 1'b0;
    // NaNs are returned as the canonical quiet NaN carrying the NaN operand's sign.
    if (a_nan_s) begin
      p_o       = {a_i[W-1], {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      invalid_o = 1'b1;
    end else if (b_nan_s) begin
      p_o       = {b_i[W-1], {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      invalid_o = 1'b1;
    end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      p_o       = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      invalid_o = 1'b1;
    end else if (a_inf_s || b_inf_s) begin
      p_o        = {sign_s, {EW{1'b1}}, {MW{1'b0}}};
      overflow_o = 1'b1;
    end else if (a_zero_s || b_zero_s) begin
      p_o = {sign_s, {(W-1){1'b0}}};
    end else if (exp_s >= EMAX) begin
      p_o        = {sign_s, {EW{1'b1}}, {MW{1'b0}}};
      overflow_o = 1'b1;
    end else if (exp_s <= 0) begin
      p_o         = {sign_s, {(W-1){1'b0}}};
      underflow_o = 1'b1;
    end else begin
      p_o = {sign_s, exp_s[EW-1:0], mant_r_s[MW-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin requester selection: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NumReq   = 4,
  parameter int IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   grant_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % NumReq]) begin
        idx_o   = IdxWidth'((int'(ptr_i) + off) % NumReq);
        valid_o = 1'b1;
      end else begin
        idx_o   = idx_o;
      end
    end
    grant_o[idx_o] = valid_o;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// N requesters share one multiplier through a round-robin grant and a 1-entry output stage.
// Optional sticky exception flags are built when FP_MUL_ARB_STICKY_FLAGS_EN is defined.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int ExponentWidth = EXP_WIDTH_DEF,
  parameter int MantissaWidth = MANT_WIDTH_DEF,
  parameter int NumRequesters = NUM_REQ_DEF
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [NumRequesters-1:0]                                   req_valid,
  output logic [NumRequesters-1:0]                                   req_ready,
  input  logic [NumRequesters*(ExponentWidth+MantissaWidth+1)-1:0]   req_a,
  input  logic [NumRequesters*(ExponentWidth+MantissaWidth+1)-1:0]   req_b,
  output logic                                                       resp_valid,
  input  logic                                                       resp_ready,
  output logic [ExponentWidth+MantissaWidth:0]                       resp_data,
  output logic [$clog2(NumRequesters)-1:0]                           resp_id,
  output logic                                                       resp_underflow,
  output logic                                                       resp_overflow,
  output logic                                                       resp_invalid
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  ,
  input  logic                                                       flags_clear,
  output logic                                                       sticky_underflow,
  output logic                                                       sticky_overflow,
  output logic                                                       sticky_invalid
`endif
);
  localparam int W  = ExponentWidth + MantissaWidth + 1;
  localparam int IW = $clog2(NumRequesters);

  out_state_e             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, gidx_s, id_q;
  logic [NumRequesters-1:0] grant_s;
  logic                   any_s, can_accept_s, xfer_s;
  logic [W-1:0]           a_sel_s, b_sel_s, prod_s, data_q;
  logic                   uf_s, of_s, inv_s, uf_q, of_q, inv_q;

  rr_arbiter #(.NumReq(NumRequesters), .IdxWidth(IW)) u_rr (
    .req_i(req_valid), .ptr_i(ptr_q), .grant_o(grant_s), .idx_o(gidx_s), .valid_o(any_s)
  );

  assign a_sel_s = req_a[gidx_s*W +: W];
  assign b_sel_s = req_b[gidx_s*W +: W];

  floating_point_multiplier #(.ExponentWidth(ExponentWidth), .MantissaWidth(MantissaWidth)) u_mul (
    .a_i(a_sel_s), .b_i(b_sel_s), .p_o(prod_s),
    .underflow_o(uf_s), .overflow_o(of_s), .invalid_o(inv_s)
  );

  assign can_accept_s = (state_q == EMPTY) || resp_ready;
  assign req_ready    = (can_accept_s && !rst) ? grant_s : '0;
  assign xfer_s       = any_s && can_accept_s && !rst;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY:   state_d = xfer_s ? FULL : EMPTY;
      FULL:    state_d = (xfer_s || !resp_ready) ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer_s) begin
      ptr_d = (gidx_s == IW'(NumRequesters - 1)) ? '0 : gidx_s + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer_s) begin
        data_q <= prod_s;
        id_q   <= gidx_s;
        uf_q   <= uf_s;
        of_q   <= of_s;
        inv_q  <= inv_s;
      end
    end
  end

  assign resp_valid     = (state_q == FULL);
  assign resp_data      = data_q;
  assign resp_id        = id_q;
  assign resp_underflow = uf_q;
  assign resp_overflow  = of_q;
  assign resp_invalid   = inv_q;

`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;
  logic       fire_s;

  assign fire_s = resp_valid && resp_ready;

  // A flag raised on the same cycle as flags_clear survives the clear.
  always_comb begin
    sticky_d = flags_clear ? 3'b000 : sticky_q;
    if (fire_s) begin
      sticky_d = sticky_d | {uf_q, of_q, inv_q};
    end else begin
      sticky_d = sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_underflow = sticky_q[2];
  assign sticky_overflow  = sticky_q[1];
  assign sticky_invalid   = sticky_q[0];
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed scoreboard bench for fp_mul_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares on every response handshake.
module tb_fp_mul_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic [2:0]  flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;
  logic         resp_underflow, resp_overflow, resp_invalid;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  logic         flags_clear;
  logic         sticky_underflow, sticky_overflow, sticky_invalid;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  fp_mul_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_underflow(resp_underflow),
    .resp_overflow(resp_overflow), .resp_invalid(resp_invalid)
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    , .flags_clear(flags_clear), .sticky_underflow(sticky_underflow),
    .sticky_overflow(sticky_overflow), .sticky_invalid(sticky_invalid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[k*32 +: 32] = a;
    req_b[k*32 +: 32] = b;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] id, input logic [2:0] fl);
    exp_t e;
    e.data = d; e.id = id; e.flags = fl;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", {30'd0, resp_id}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_id", {30'd0, resp_id}, {30'd0, e.id});
        chk("resp_flags", {29'd0, resp_underflow, resp_overflow, resp_invalid}, {29'd0, e.flags});
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; resp_ready = 1'b1;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    flags_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_id", {30'd0, resp_id}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);

    // Single request: 3.0 * 4.0, one-cycle latency.
    step();
    rst = 1'b0; req_valid = 4'b0001;
    set_op(0, 32'h4040_0000, 32'h4080_0000);
    push(32'h4140_0000, 2'd0, 3'b000);
    @(negedge clk); chk("single_grant", {28'd0, req_ready}, 32'h1);
    step(); req_valid = 4'b0000;
    @(negedge clk); chk("single_latency", {31'd0, resp_valid}, 32'd1);
    step();

    // Fairness from a fresh pointer: grants 0,1,2,3,0 back-to-back.
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) set_op(k, 32'h3F80_0000, 32'h4000_0000 + (k * 32'h0040_0000));
    set_op(3, 32'hBF80_0000, 32'h40A0_0000);
    push(32'h4000_0000, 2'd0, 3'b000); push(32'h4040_0000, 2'd1, 3'b000);
    push(32'h4080_0000, 2'd2, 3'b000); push(32'hC0A0_0000, 2'd3, 3'b000);
    push(32'h4000_0000, 2'd0, 3'b000);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", {28'd0, req_ready}, 32'(1 << (i % 4)));
      if (i > 0) chk("rr_throughput", {31'd0, resp_valid}, 32'd1);
      step();
    end
    req_valid = 4'b0000;
    step(); step();

    // Backpressure: hold 2*3 for three cycles, then 2*2 follows with no gap.
    resp_ready = 1'b0; req_valid = 4'b0110;
    set_op(1, 32'h4000_0000, 32'h4040_0000);
    set_op(2, 32'h4000_0000, 32'h4000_0000);
    push(32'h40C0_0000, 2'd1, 3'b000); push(32'h4080_0000, 2'd2, 3'b000);
    @(negedge clk); chk("bp_grant", {28'd0, req_ready}, 32'h2);
    step(); req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data", resp_data, 32'h40C0_0000);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk); chk("bp_release_grant", {28'd0, req_ready}, 32'h4);
    step(); req_valid = 4'b0000;
    @(negedge clk); chk("bp_no_gap", {31'd0, resp_valid}, 32'd1);
    step();

    // Exceptions: SNaN*0 on req1, +Inf*3 on req2, min-subnormal squared on req0.
    req_valid = 4'b0110;
    set_op(1, 32'hFFA0_0000, 32'h0000_0000);
    set_op(2, 32'h7F80_0000, 32'h4040_0000);
    push(32'hFFC0_0000, 2'd1, 3'b001); push(32'h7F80_0000, 2'd2, 3'b010);
    push(32'h0000_0000, 2'd0, 3'b100);
    @(negedge clk); chk("exc_grant1", {28'd0, req_ready}, 32'h2);
    step(); req_valid[1] = 1'b0;
    @(negedge clk); chk("exc_grant2", {28'd0, req_ready}, 32'h4);
    step(); req_valid = 4'b0001;
    set_op(0, 32'h0000_0001, 32'h0000_0001);
    @(negedge clk); chk("exc_grant0", {28'd0, req_ready}, 32'h1);
    step(); req_valid = 4'b0000;
    step(); step();

    // Reset while FULL discards the pending result and restarts the pointer at 0.
    resp_ready = 1'b0; req_valid = 4'b0100;
    set_op(2, 32'h3F80_0000, 32'h3F80_0000);
    step(); req_valid = 4'b0000; rst = 1'b1;
    @(negedge clk);
    chk("midrst_full", {31'd0, resp_valid}, 32'd1);
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    step(); rst = 1'b0; resp_ready = 1'b1; req_valid = 4'b1111;
    set_op(0, 32'h3FC0_0000, 32'h3FC0_0000);
    push(32'h4010_0000, 2'd0, 3'b000);
    @(negedge clk);
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_data", resp_data, 32'd0);
    chk("midrst_ptr0", {28'd0, req_ready}, 32'h1);
    step(); req_valid = 4'b0000;
    step(); step();

`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    // Underflow then a normal product: sticky bit persists until flags_clear.
    req_valid = 4'b0001;
    set_op(0, 32'h0000_0001, 32'h0000_0001);
    push(32'h0000_0000, 2'd0, 3'b100); push(32'h4140_0000, 2'd0, 3'b000);
    step(); set_op(0, 32'h4040_0000, 32'h4080_0000);
    step(); req_valid = 4'b0000;
    @(negedge clk); chk("sticky_set", {31'd0, sticky_underflow}, 32'd1);
    step();
    @(negedge clk); chk("sticky_hold", {31'd0, sticky_underflow}, 32'd1);
    chk("sticky_of_clear", {31'd0, sticky_overflow}, 32'd0);
    step(); flags_clear = 1'b1;
    step(); flags_clear = 1'b0;
    @(negedge clk); chk("sticky_cleared", {31'd0, sticky_underflow}, 32'd0);
    step();
`endif

    repeat (3) step();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- ExponentWidth, 8, exponent bits.
- MantissaWidth, 23, mantissa bits.
- NumRequesters, 4, requester count (2..8).
REQ-003 Ports SHALL be, in this order (W = ExponentWidth+MantissaWidth+1, N = NumRequesters, I = clog2(N)):
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- req_valid  in  N  per-requester operand valid.
- req_ready  out  N  per-requester accept.
- req_a  in  N*W  operand A, requester k in slice [k*W +: W].
- req_b  in  N*W  operand B, same packing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accept.
- resp_data  out  W  product.
- resp_id  out  I  originating requester index.
- resp_underflow, resp_overflow, resp_invalid  out  1 each  exception flags of that product.

Function
REQ-004 The block SHALL share one combinational floating_point_multiplier (same parameters) among N requesters.
REQ-005 Output stage FSM SHALL have states EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-006 The grant SHALL be computed combinationally each cycle by round-robin from pointer ptr: the first k with req_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-007 can_accept SHALL be (state==EMPTY) || resp_ready; req_ready[k] SHALL be 1 only for the granted k while can_accept=1. All other bits SHALL be 0.
REQ-008 On a transfer (req_valid[k] && req_ready[k]) the product, flags and k SHALL be registered into the output stage, so latency is exactly 1 cycle. State SHALL go to FULL and ptr SHALL become (k+1) mod N.
REQ-009 In FULL with resp_ready=1 and no new transfer, state SHALL go to EMPTY. With simultaneous drain and transfer, state SHALL stay FULL with new data, giving back-to-back throughput of 1 per cycle.
REQ-010 In FULL with resp_ready=0, resp_data, resp_id and flags SHALL hold stable and req_ready SHALL be all 0.
REQ-011 With no req_valid, ptr SHALL be unchanged.
REQ-012 Results SHALL be bit-identical to the standalone multiplier, including NaN quieting (SNaN 0xFFA00000 -> 0xFFC00000) and the flag semantics.

Reset
REQ-013 While rst=1: state SHALL be EMPTY, ptr SHALL be 0, resp_valid SHALL be 0, and resp_data, resp_id and all flags SHALL be 0. req_ready SHALL be 0 during reset.
REQ-014 Reset asserted while FULL SHALL discard the pending result without a handshake.

Configuration
REQ-015 With macro FP_MUL_ARB_STICKY_FLAGS_EN defined, the block SHALL add:
- input flags_clear (1 bit).
- outputs sticky_underflow, sticky_overflow, sticky_invalid, each set by the corresponding flag on any resp_valid&&resp_ready transfer and cleared by rst or flags_clear.
- Set SHALL win over a simultaneous flags_clear.
REQ-016 Without the macro, those ports and registers SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-017 Shared package fp_pkg SHALL hold the default width constants and the output-state enum (EMPTY/FULL).
REQ-018 The round-robin grant logic SHALL be a sub-module rr_arbiter (req, ptr -> one-hot grant, index). The multiplier SHALL be instanced, not duplicated.

Verification
REQ-019 Single request: req0 a=0x40400000, b=0x40800000 with resp_ready=1 -> next cycle resp_valid=1, resp_data=0x41400000, resp_id=0, flags 0.
REQ-020 Fairness: all 4 requesters valid continuously with resp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-021 Backpressure: resp_ready=0 for 3 cycles while FULL -> resp_data stable, req_ready=0; on release the next result follows with no gap.
REQ-022 Exceptions: req2 a=0x7F800000 (+Inf), b=0x40400000 -> resp_data=0x7F800000, resp_overflow=1, resp_id=2. Req1 a=0xFFA00000, b=0x00000000 -> 0xFFC00000, resp_invalid=1.
REQ-023 Reset mid-FULL: rst pulsed while resp_valid=1 -> next cycle resp_valid=0, ptr=0, and req0 is granted first.
REQ-024 With FP_MUL_ARB_STICKY_FLAGS_EN: after 0x00000001*0x00000001 (underflow) then a normal product -> sticky_underflow stays 1 until flags_clear.
